// File: rtl/aes128_key_expander_if.sv
// Bundles the key load handshake and the round key bus shared by the key
// expander and the encrypt datapath that consumes its schedule.
interface aes128_key_expander_if;
    logic                   key_valid;
    logic [127:0]           key_in;
    logic [10:0][127:0]     round_keys;
    logic                   keys_valid;
    logic                   busy;

    modport master (
        output key_valid,
        output key_in,
        input  round_keys,
        input  keys_valid,
        input  busy
    );

    modport slave (
        input  key_valid,
        input  key_in,
        output round_keys,
        output keys_valid,
        output busy
    );
endinterface

// File: rtl/aes128_key_expander.sv
// Iterative AES-128 key schedule: loads a cipher key and writes one round key
// per clock into an 11-entry parallel bus, flagging when the schedule is whole.
module aes128_key_expander (
    input  logic                    clk,
    input  logic                    rst_n,
    aes128_key_expander_if.slave    kif
);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t                 state;
    logic [3:0]             round_cnt;
    logic [10:0][127:0]     round_keys_q;
    logic                   keys_valid_q;
    logic                   busy_q;

    logic [3:0]             prev_idx;
    logic [127:0]           prev_key;
    logic [31:0]            rot_word;
    logic [31:0]            sub_word;
    logic [31:0]            temp_word;
    logic [7:0]             rcon;
    logic [31:0]            n0;
    logic [31:0]            n1;
    logic [31:0]            n2;
    logic [31:0]            n3;
    logic [127:0]           next_key;

    always_comb begin
        case (round_cnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Round r is derived from round r-1; the guard keeps the read in range while idle.
    always_comb begin
        prev_idx  = (round_cnt == 4'd0) ? 4'd0 : round_cnt - 4'd1;
        prev_key  = round_keys_q[prev_idx];
        rot_word  = {prev_key[23:0], prev_key[31:24]};
        sub_word  = '0;
        for (int b = 0; b < 4; b++) begin
            sub_word[8*b +: 8] = SBOX[rot_word[8*b +: 8]];
        end
        temp_word = sub_word ^ {rcon, 24'h0};
        n0        = prev_key[127:96] ^ temp_word;
        n1        = prev_key[95:64]  ^ n0;
        n2        = prev_key[63:32]  ^ n1;
        n3        = prev_key[31:0]   ^ n2;
        next_key  = {n0, n1, n2, n3};
    end

    // A load wins over everything else, so a new key always restarts the schedule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            round_cnt    <= 4'd0;
            round_keys_q <= '0;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else if (kif.key_valid) begin
            round_keys_q[0] <= kif.key_in;
            round_cnt       <= 4'd1;
            busy_q          <= 1'b1;
            keys_valid_q    <= 1'b0;
            state           <= EXPAND;
        end else if (state == EXPAND) begin
            round_keys_q[round_cnt] <= next_key;
            if (round_cnt == 4'd10) begin
                round_cnt    <= 4'd0;
                busy_q       <= 1'b0;
                keys_valid_q <= 1'b1;
                state        <= IDLE;
            end else begin
                round_cnt <= round_cnt + 4'd1;
            end
        end
    end

    assign kif.round_keys = round_keys_q;
    assign kif.keys_valid = keys_valid_q;
    assign kif.busy       = busy_q;

endmodule

// File: tb/tb_aes128_key_expander.sv
// Randomised and known-answer bench for aes128_key_expander against a
// FIPS-197 word-by-word reference model with an arithmetically built S-box.
module tb_aes128_key_expander;

    typedef logic [10:0][127:0] rk_t;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;
    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] sbox_m [256];

    aes128_key_expander_if kif();

    aes128_key_expander dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic buildSbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gf_mul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic rk_t modelExpand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        rk_t         r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) r[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return r;
    endfunction

    function automatic logic [127:0] randKey();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkAllKeys(input string tag, input rk_t exp);
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("%s rk[%0d]", tag, i), kif.round_keys[i], exp[i]);
        end
    endtask

    // Pulses key_valid for one sampled edge, then scrambles key_in.
    task automatic applyStimulus(input logic [127:0] key);
        @(negedge clk);
        kif.key_valid = 1'b1;
        kif.key_in    = key;
        @(posedge clk);
        #1;
        kif.key_valid = 1'b0;
        kif.key_in    = randKey();
    endtask

    // Returns right after the edge where keys_valid is first seen, bounded.
    task automatic waitComplete(input string tag, input int exp_lat);
        int lat = 0;
        for (int k = 1; k <= exp_lat + 5; k++) begin
            @(posedge clk);
            #1;
            if (kif.keys_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (k <= exp_lat) checkOutput($sformatf("%s busy@%0d", tag, k), 128'(kif.busy), 128'(1));
        end
        checkOutput($sformatf("%s latency", tag), 128'(lat), 128'(exp_lat));
        checkOutput($sformatf("%s busy done", tag), 128'(kif.busy), 128'(0));
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput($sformatf("%s keys_valid", tag), 128'(kif.keys_valid), 128'(0));
        checkOutput($sformatf("%s busy", tag), 128'(kif.busy), 128'(0));
        checkAllKeys(tag, '0);
    endtask

    initial begin
        rk_t exp_rk;
        logic [127:0] last_key;
        int held;
        int gap;

        buildSbox();
        rst_n         = 1'b0;
        kif.key_valid = 1'b0;
        kif.key_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] FIPS-197 A.1 key");
        applyStimulus(KEY_A1);
        waitComplete("a1", 10);
        exp_rk = modelExpand(KEY_A1);
        checkOutput("a1 kat rk1", kif.round_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("a1 kat rk10", kif.round_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkAllKeys("a1", exp_rk);

        $display("[TB] hold with key_in toggling");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            kif.key_in = randKey();
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold kv@%0d", c), 128'(kif.keys_valid), 128'(1));
            checkOutput($sformatf("hold rk10@%0d", c), kif.round_keys[10], exp_rk[10]);
        end
        checkAllKeys("hold", exp_rk);

        $display("[TB] zero key");
        applyStimulus(KEY_ZERO);
        waitComplete("zero", 10);
        checkOutput("zero kat rk1", kif.round_keys[1], 128'h62636363626363636263636362636363);
        checkOutput("zero kat rk10", kif.round_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        checkAllKeys("zero", modelExpand(KEY_ZERO));

        $display("[TB] sequential key");
        applyStimulus(KEY_SEQ);
        waitComplete("seq", 10);
        checkOutput("seq kat rk10", kif.round_keys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        checkAllKeys("seq", modelExpand(KEY_SEQ));

        $display("[TB] restart at N+4");
        applyStimulus(KEY_A1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("restart kv@%0d", k), 128'(kif.keys_valid), 128'(0));
        end
        applyStimulus(KEY_ZERO);
        checkOutput("restart kv@4", 128'(kif.keys_valid), 128'(0));
        waitComplete("restart", 10);
        checkOutput("restart kat rk10", kif.round_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        checkAllKeys("restart", modelExpand(KEY_ZERO));

        $display("[TB] reset mid-expansion");
        applyStimulus(KEY_SEQ);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkIdleReset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("midreset kv after", 128'(kif.keys_valid), 128'(0));
        checkOutput("midreset busy after", 128'(kif.busy), 128'(0));

        $display("[TB] randomised loads, holds and restarts");
        for (int it = 0; it < 10; it++) begin
            held = $urandom_range(1, 3);
            for (int j = 0; j < held; j++) begin
                @(negedge clk);
                kif.key_valid = 1'b1;
                last_key      = randKey();
                kif.key_in    = last_key;
                @(posedge clk);
                #1;
            end
            kif.key_valid = 1'b0;
            kif.key_in    = randKey();
            if ($urandom_range(0, 1) == 1) begin
                gap = $urandom_range(0, 8);
                repeat (gap) @(posedge clk);
                #1;
                checkOutput($sformatf("rand%0d kv pre", it), 128'(kif.keys_valid), 128'(0));
                last_key = randKey();
                applyStimulus(last_key);
            end
            waitComplete($sformatf("rand%0d", it), 10);
            checkAllKeys($sformatf("rand%0d", it), modelExpand(last_key));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
